// File: rtl/core_pkg.sv
// Core-wide constants and types shared by the result-broadcast path.
package core_pkg;
    localparam int unsigned ISSUE_WIDTH = 2;
    localparam int unsigned PREGS       = 64;
    localparam int unsigned N_FU        = 4;
    localparam int unsigned PTAG_W      = $clog2(PREGS);
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ROB_W       = 5;

    typedef logic [PTAG_W-1:0] preg_tag_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result requests in, common-data-bus broadcast out.
interface cdb_arbiter_if
    import core_pkg::*;
#(
    parameter int unsigned N_REQ = N_FU,
    parameter int unsigned CDB_W = ISSUE_WIDTH,
    parameter int unsigned TAG_W = PTAG_W
);
    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0][TAG_W-1:0]     req_tag;
    logic [N_REQ-1:0][DATA_W-1:0]    req_value;
    logic [N_REQ-1:0][ROB_W-1:0]     req_rob;
    logic                            flush;
    logic [CDB_W-1:0]                cdb_valid;
    logic [CDB_W-1:0][TAG_W-1:0]     cdb_tag;
    logic [CDB_W-1:0][DATA_W-1:0]    cdb_value;
    logic [CDB_W-1:0][ROB_W-1:0]     cdb_rob;
    logic                            cdb_busy;

    modport master (
        output req_valid, req_tag, req_value, req_rob, flush,
        input  req_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob, cdb_busy
    );

    modport slave (
        input  req_valid, req_tag, req_value, req_rob, flush,
        output req_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob, cdb_busy
    );
endinterface

// File: rtl/rr_pick_n.sv
// Circular priority pick: up to G one-hot grants, scanning req from ptr upward.
module rr_pick_n
    import core_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned G  = 2,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]        req,
    input  logic [PW-1:0]       ptr,
    output logic [G-1:0][N-1:0] gnt,
    output logic [G-1:0]        gnt_vld
);
    logic [N-1:0]  rem;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_vld = '0;
        rem     = req;
        sum     = '0;
        idx     = '0;
        found   = 1'b0;
        for (int s = 0; s < G; s++) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                sum = {1'b0, ptr} + (PW+1)'(k);
                if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
                idx = sum[PW-1:0];
                if (!found && rem[idx]) begin
                    gnt[s][idx] = 1'b1;
                    gnt_vld[s]  = 1'b1;
                    rem[idx]    = 1'b0;
                    found       = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: starving FUs first, then round-robin; grants broadcast one cycle later.
module cdb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned N_REQ      = N_FU,
    parameter int unsigned CDB_W      = ISSUE_WIDTH,
    parameter int unsigned TAG_W      = PTAG_W,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic         clk,
    input  logic         reset,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WC_W  = $clog2(STARVE_LIM + 1);

    logic [N_REQ-1:0][WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [CDB_W-1:0]             cdb_valid_q, cdb_valid_d;
    logic [CDB_W-1:0][TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [CDB_W-1:0][DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [CDB_W-1:0][ROB_W-1:0]  cdb_rob_q, cdb_rob_d;

    logic [N_REQ-1:0]             starving, st_gnt, st_rem, rr_req, ready;
    logic [CDB_W-1:0][N_REQ-1:0]  st_sel, rr_gnt, port_sel;
    logic [CDB_W-1:0]             rr_vld, port_vld;
    logic                         st_found;
    int                           n_st;
    int unsigned                  n_valid;

    // Starving requesters claim ports in ascending index order.
    always_comb begin
        starving = '0;
        st_sel   = '0;
        st_gnt   = '0;
        st_found = 1'b0;
        n_st     = 0;
        for (int i = 0; i < N_REQ; i++)
            starving[i] = bus.req_valid[i] && (wait_cnt_q[i] == WC_W'(STARVE_LIM));
        st_rem = starving;
        for (int s = 0; s < CDB_W; s++) begin
            st_found = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (!st_found && st_rem[i]) begin
                    st_sel[s][i] = 1'b1;
                    st_rem[i]    = 1'b0;
                    st_found     = 1'b1;
                end
            end
            if (st_found) n_st = n_st + 1;
            st_gnt = st_gnt | st_sel[s];
        end
        rr_req = bus.req_valid & ~st_gnt;
    end

    rr_pick_n #(
        .N  (N_REQ),
        .G  (CDB_W),
        .PW (PTR_W)
    ) u_rr_pick (
        .req     (rr_req),
        .ptr     (rr_ptr_q),
        .gnt     (rr_gnt),
        .gnt_vld (rr_vld)
    );

    // Round-robin grants fill the ports left after the starvation stage.
    always_comb begin
        port_sel = st_sel;
        port_vld = '0;
        rr_ptr_d = rr_ptr_q;
        ready    = '0;
        for (int s = 0; s < CDB_W; s++) begin
            if (s < n_st) begin
                port_vld[s] = 1'b1;
            end else begin
                for (int j = 0; j < CDB_W; j++) begin
                    if ((j + n_st == s) && rr_vld[j]) begin
                        port_sel[s] = rr_gnt[j];
                        port_vld[s] = 1'b1;
                        for (int i = 0; i < N_REQ; i++)
                            if (rr_gnt[j][i]) rr_ptr_d = PTR_W'((i + 1) % N_REQ);
                    end
                end
            end
        end
        if (reset || bus.flush) begin
            port_sel = '0;
            port_vld = '0;
            rr_ptr_d = rr_ptr_q;
        end
        for (int s = 0; s < CDB_W; s++) ready = ready | port_sel[s];
    end

    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        cdb_valid_d = port_vld;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        cdb_rob_d   = cdb_rob_q;
        n_valid     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.flush || !bus.req_valid[i] || ready[i])
                wait_cnt_d[i] = '0;
            else if (wait_cnt_q[i] != WC_W'(STARVE_LIM))
                wait_cnt_d[i] = wait_cnt_q[i] + WC_W'(1);
            if (bus.req_valid[i]) n_valid = n_valid + 1;
        end
        for (int s = 0; s < CDB_W; s++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (port_vld[s] && port_sel[s][i]) begin
                    cdb_tag_d[s]   = bus.req_tag[i];
                    cdb_value_d[s] = bus.req_value[i];
                    cdb_rob_d[s]   = bus.req_rob[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_rob_q   <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_rob_q   <= cdb_rob_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.cdb_busy  = !reset && !bus.flush && (n_valid > CDB_W);
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_value = cdb_value_q;
    assign bus.cdb_rob   = cdb_rob_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a default instance and a 1-port, STARVE_LIM=1 instance vs. a grant-list model.
module tb_cdb_arbiter;
    logic clk;
    logic reset;

    cdb_arbiter_if #(.N_REQ(4), .CDB_W(2), .TAG_W(6)) if_a ();
    cdb_arbiter_if #(.N_REQ(4), .CDB_W(1), .TAG_W(6)) if_b ();

    cdb_arbiter #(.N_REQ(4), .CDB_W(2), .TAG_W(6), .STARVE_LIM(4)) u_a (
        .clk(clk), .reset(reset), .bus(if_a));
    cdb_arbiter #(.N_REQ(4), .CDB_W(1), .TAG_W(6), .STARVE_LIM(1)) u_b (
        .clk(clk), .reset(reset), .bus(if_b));

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // stimulus per instance
    logic [3:0]  m_v [2];
    logic        m_fl [2];
    logic [5:0]  p_tag [2][4];
    logic [31:0] p_val [2][4];
    logic [4:0]  p_rob [2][4];
    bit          pend [2][4];

    // reference state: per-requester wait count, pointer, expected broadcast
    int          m_wait [2][4];
    int          m_ptr [2];
    int          e_ord [2][4];
    int          e_n [2];
    int          e_last [2];
    logic [3:0]  e_gm [2];
    logic        e_busy [2];
    logic [1:0]        x_cv [2];
    logic [1:0][5:0]   x_tag [2];
    logic [1:0][31:0]  x_val [2];
    logic [1:0][4:0]   x_rob [2];

    function automatic int lim_of(input int d); return (d == 0) ? 4 : 1; endfunction
    function automatic int g_of(input int d);   return (d == 0) ? 2 : 1; endfunction

    // Grant list: starving FUs by index, then circular from the pointer, capped at the port count.
    function automatic void eval(input int d);
        int n, i, g, lim;
        g = g_of(d); lim = lim_of(d); n = 0;
        e_gm[d] = '0; e_last[d] = -1; e_busy[d] = 1'b0;
        if (!reset && !m_fl[d]) begin
            for (int k = 0; k < 4; k++)
                if (m_v[d][k] && m_wait[d][k] == lim && n < g) begin
                    e_ord[d][n] = k; e_gm[d][k] = 1'b1; n++;
                end
            for (int k = 0; k < 4; k++) begin
                i = (m_ptr[d] + k) % 4;
                if (m_v[d][i] && !e_gm[d][i] && n < g) begin
                    e_ord[d][n] = i; e_gm[d][i] = 1'b1; n++; e_last[d] = i;
                end
            end
            e_busy[d] = ($countones(m_v[d]) > g);
        end
        e_n[d] = n;
    endfunction

    function automatic void commit(input int d);
        int lim;
        lim = lim_of(d);
        if (reset) begin
            x_cv[d] = '0; x_tag[d] = '0; x_val[d] = '0; x_rob[d] = '0; m_ptr[d] = 0;
            for (int k = 0; k < 4; k++) begin m_wait[d][k] = 0; pend[d][k] = 0; end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            x_cv[d][p] = (p < e_n[d]);
            if (p < e_n[d]) begin
                x_tag[d][p] = p_tag[d][e_ord[d][p]];
                x_val[d][p] = p_val[d][e_ord[d][p]];
                x_rob[d][p] = p_rob[d][e_ord[d][p]];
            end
        end
        if (e_last[d] >= 0) m_ptr[d] = (e_last[d] + 1) % 4;
        for (int k = 0; k < 4; k++) begin
            pend[d][k] = m_v[d][k] && !e_gm[d][k];
            if (m_fl[d] || !pend[d][k]) m_wait[d][k] = 0;
            else if (m_wait[d][k] < lim) m_wait[d][k] = m_wait[d][k] + 1;
        end
    endfunction

    task automatic push(input int d);
        if (d == 0) begin
            if_a.req_valid = m_v[0]; if_a.flush = m_fl[0];
            for (int k = 0; k < 4; k++) begin
                if_a.req_tag[k] = p_tag[0][k]; if_a.req_value[k] = p_val[0][k]; if_a.req_rob[k] = p_rob[0][k];
            end
        end else begin
            if_b.req_valid = m_v[1]; if_b.flush = m_fl[1];
            for (int k = 0; k < 4; k++) begin
                if_b.req_tag[k] = p_tag[1][k]; if_b.req_value[k] = p_val[1][k]; if_b.req_rob[k] = p_rob[1][k];
            end
        end
        eval(d);
    endtask

    // Pending requesters keep their payload; everyone else gets a fresh random one.
    task automatic apply(input int d, input logic [3:0] v, input logic fl);
        m_v[d] = v; m_fl[d] = fl;
        for (int k = 0; k < 4; k++)
            if (!pend[d][k]) begin
                p_tag[d][k] = 6'($urandom); p_val[d][k] = $urandom; p_rob[d][k] = 5'($urandom);
            end
        push(d);
    endtask

    task automatic advance();
        eval(0); eval(1);
        @(posedge clk); #1;
        commit(0); commit(1);
    endtask

    function automatic logic [87:0] obs_cdb(input int d);
        if (d == 0) return {if_a.cdb_valid, if_a.cdb_tag, if_a.cdb_value, if_a.cdb_rob};
        return 88'({if_b.cdb_valid, if_b.cdb_tag, if_b.cdb_value, if_b.cdb_rob});
    endfunction
    function automatic logic [87:0] exp_cdb(input int d);
        if (d == 0) return {x_cv[0], x_tag[0], x_val[0], x_rob[0]};
        return 88'({x_cv[1][0], x_tag[1][0], x_val[1][0], x_rob[1][0]});
    endfunction
    function automatic logic [4:0] obs_rdy(input int d);
        return (d == 0) ? {if_a.cdb_busy, if_a.req_ready} : {if_b.cdb_busy, if_b.req_ready};
    endfunction
    function automatic logic [4:0] exp_rdy(input int d);
        return {e_busy[d], e_gm[d]};
    endfunction

    task automatic pulse_reset();
        reset = 1'b1; apply(0, 4'b0000, 1'b0); apply(1, 4'b0000, 1'b0);
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(0, 4'b1111, 1'b1); apply(1, 4'b1111, 1'b0); #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_rdy(d) !== 5'b0) begin
                $display("FAIL reset_ready dut%0d: got %b want 00000", d, obs_rdy(d)); miscompares++;
            end
        end
        advance();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_cdb(d) !== 88'b0) begin
                $display("FAIL reset_cdb dut%0d: got %h want 0", d, obs_cdb(d)); miscompares++;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        apply(0, 4'b0001, 1'b0);
        p_tag[0][0] = 6'd10; p_val[0][0] = 32'd8; p_rob[0][0] = 5'd0; push(0); #1;
        vectors++;
        if (if_a.req_ready !== 4'b0001 || obs_rdy(0) !== exp_rdy(0)) begin
            $display("FAIL single_ready: got %b want 0001", if_a.req_ready); miscompares++;
        end
        advance();
        vectors++;
        if (if_a.cdb_valid !== 2'b01 || if_a.cdb_tag[0] !== 6'd10 || if_a.cdb_value[0] !== 32'd8
            || obs_cdb(0) !== exp_cdb(0)) begin
            $display("FAIL single_cdb: got v=%b tag=%0d val=%0d want v=01 tag=10 val=8",
                     if_a.cdb_valid, if_a.cdb_tag[0], if_a.cdb_value[0]); miscompares++;
        end
        apply(0, 4'b0000, 1'b0); advance();
        vectors++;
        if (obs_cdb(0) !== exp_cdb(0)) begin
            $display("FAIL single_idle_hold: got %h want %h", obs_cdb(0), exp_cdb(0)); miscompares++;
        end
    endtask

    task automatic test_contention();
        logic [3:0] want [3];
        want[0] = 4'b0011; want[1] = 4'b1100; want[2] = 4'b0011;
        pulse_reset();
        for (int c = 0; c < 3; c++) begin
            apply(0, 4'b1111, 1'b0); #1;
            vectors++;
            if (if_a.req_ready !== want[c] || if_a.cdb_busy !== 1'b1 || obs_rdy(0) !== exp_rdy(0)) begin
                $display("FAIL contention_ready c%0d: got rdy=%b busy=%b want rdy=%b busy=1",
                         c, if_a.req_ready, if_a.cdb_busy, want[c]); miscompares++;
            end
            advance();
            vectors++;
            if (if_a.cdb_valid !== 2'b11 || obs_cdb(0) !== exp_cdb(0)) begin
                $display("FAIL contention_cdb c%0d: got %h want %h", c, obs_cdb(0), exp_cdb(0)); miscompares++;
            end
        end
    endtask

    task automatic test_starvation();
        int c3;
        c3 = -1;
        pulse_reset();
        for (int c = 0; c < 8 && c3 < 0; c++) begin
            apply(0, 4'b1011, 1'b0);
            p_rob[0][0] = 5'd1; p_rob[0][1] = 5'd2; p_rob[0][3] = 5'd31; push(0); #1;
            vectors++;
            if (obs_rdy(0) !== exp_rdy(0)) begin
                $display("FAIL starve_ready c%0d: got %b want %b", c, obs_rdy(0), exp_rdy(0)); miscompares++;
            end
            if (e_gm[0][3]) c3 = c;
            advance();
            vectors++;
            if (obs_cdb(0) !== exp_cdb(0)) begin
                $display("FAIL starve_cdb c%0d: got %h want %h", c, obs_cdb(0), exp_cdb(0)); miscompares++;
            end
        end
        vectors++;
        if (c3 < 0 || c3 > 4 || if_a.cdb_valid[0] !== 1'b1 || if_a.cdb_rob[0] !== 5'd31) begin
            $display("FAIL starve_req3: granted after %0d waits, port0 v=%b rob=%0d want <=4 waits, v=1 rob=31",
                     c3, if_a.cdb_valid[0], if_a.cdb_rob[0]); miscompares++;
        end
        // single port, limit 1: every loser starves immediately and the lowest index wins
        for (int c = 0; c < 8; c++) begin
            apply(1, 4'b1111, 1'b0); #1;
            vectors++;
            if (obs_rdy(1) !== exp_rdy(1)) begin
                $display("FAIL starve1_ready c%0d: got %b want %b", c, obs_rdy(1), exp_rdy(1)); miscompares++;
            end
            advance();
            vectors++;
            if (obs_cdb(1) !== exp_cdb(1)) begin
                $display("FAIL starve1_cdb c%0d: got %h want %h", c, obs_cdb(1), exp_cdb(1)); miscompares++;
            end
        end
    endtask

    task automatic test_flush();
        for (int d = 0; d < 2; d++) begin
            apply(d, 4'b1111, 1'b0); advance();
            apply(d, 4'b0011, 1'b1); #1;
            vectors++;
            if (obs_rdy(d) !== 5'b0) begin
                $display("FAIL flush_ready dut%0d: got %b want 00000", d, obs_rdy(d)); miscompares++;
            end
            advance();
            vectors++;
            if (obs_cdb(d) !== exp_cdb(d) || x_cv[d] !== 2'b00) begin
                $display("FAIL flush_cdb dut%0d: got %h want %h", d, obs_cdb(d), exp_cdb(d)); miscompares++;
            end
            for (int c = 0; c < 4; c++) begin
                apply(d, 4'b1111, 1'b0); #1;
                vectors++;
                if (obs_rdy(d) !== exp_rdy(d)) begin
                    $display("FAIL post_flush_ready dut%0d c%0d: got %b want %b", d, c, obs_rdy(d), exp_rdy(d));
                    miscompares++;
                end
                advance();
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply(0, 4'b1111, 1'b0); advance();
        apply(0, 4'b1111, 1'b0); reset = 1'b1; eval(0); #1;
        vectors++;
        if (if_a.req_ready !== 4'b0000 || if_a.cdb_busy !== 1'b0) begin
            $display("FAIL midreset_ready: got rdy=%b busy=%b want 0000/0", if_a.req_ready, if_a.cdb_busy);
            miscompares++;
        end
        advance();
        vectors++;
        if (obs_cdb(0) !== 88'b0) begin
            $display("FAIL midreset_cdb: got %h want 0", obs_cdb(0)); miscompares++;
        end
        reset = 1'b0;
        apply(0, 4'b1111, 1'b0); #1;
        vectors++;
        if (if_a.req_ready !== 4'b0011) begin
            $display("FAIL midreset_ptr: got rdy=%b want 0011", if_a.req_ready); miscompares++;
        end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int d = 0; d < 2; d++)
                apply(d, 4'($urandom), ($urandom_range(0, 15) == 0));
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_rdy(d) !== exp_rdy(d)) begin
                    $display("FAIL random_ready dut%0d c%0d: got %b want %b", d, c, obs_rdy(d), exp_rdy(d));
                    miscompares++;
                end
            end
            advance();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_cdb(d) !== exp_cdb(d)) begin
                    $display("FAIL random_cdb dut%0d c%0d: got %h want %h", d, c, obs_cdb(d), exp_cdb(d));
                    miscompares++;
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        vectors = 0;
        miscompares = 0;
        for (int d = 0; d < 2; d++) begin
            m_v[d] = '0; m_fl[d] = 1'b0; m_ptr[d] = 0;
            x_cv[d] = '0; x_tag[d] = '0; x_val[d] = '0; x_rob[d] = '0;
            for (int k = 0; k < 4; k++) begin m_wait[d][k] = 0; pend[d][k] = 0; end
        end
        test_reset();
        test_single();
        test_contention();
        test_starvation();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of functional-unit requesters (0=ALU0, 1=ALU1, 2=BR, 3=MEM).
REQ-002 SHALL have parameter CDB_W, default 2 (core_pkg::ISSUE_WIDTH), number of CDB broadcast ports.
REQ-003 SHALL have parameter TAG_W, default $clog2(core_pkg::PREGS), physical-register tag width.
REQ-004 SHALL have parameter STARVE_LIM, default 4, wait cycles before a requester is promoted.
REQ-005 SHALL have ports: clk input 1, the single clock; reset input 1, synchronous active-high reset.
REQ-006 SHALL have ports: req_valid input [N_REQ], result pending per FU; req_ready output [N_REQ], grant this cycle.
REQ-007 SHALL have ports: req_tag input [N_REQ][TAG_W], req_value input [N_REQ][32], req_rob input [N_REQ][5].
REQ-008 SHALL have ports: flush input 1, pipeline flush.
REQ-009 SHALL have ports: cdb_valid output [CDB_W], cdb_tag output [CDB_W][TAG_W], cdb_value output [CDB_W][32], cdb_rob output [CDB_W][5].
REQ-010 SHALL have ports: cdb_busy output 1, asserted when more than CDB_W requests are valid this cycle.

Function
REQ-011 Handshake: a transfer occurs when req_valid[i] && req_ready[i]; a requester SHALL hold tag/value/rob stable until it is granted.
REQ-012 req_ready SHALL be combinational from req_valid, wait counters, rr_ptr and flush; at most CDB_W bits set per cycle.
REQ-013 Grant order: first, starving requesters (wait_cnt == STARVE_LIM) in ascending index; then the remaining valid requesters scanned circularly from rr_ptr; stop at CDB_W grants.
REQ-014 Port mapping: the first granted requester in grant order SHALL drive port 0, the second port 1.
REQ-015 Latency: a grant in cycle N SHALL appear on cdb_* at the output registers in cycle N+1; ungranted ports SHALL have cdb_valid=0 in N+1.
REQ-016 cdb_tag/value/rob of an invalid port SHALL hold their previous values (no requirement to zero them).
REQ-017 rr_ptr SHALL update to (index of the last round-robin-granted requester + 1) mod N_REQ; it SHALL stay unchanged if no round-robin grant occurred (starvation-only grants do not move it).
REQ-018 wait_cnt[i] SHALL increment, saturating at STARVE_LIM, when req_valid[i] && !req_ready[i]; it SHALL clear when granted or when req_valid[i]=0.
REQ-019 flush=1 SHALL force req_ready=0, clear every wait_cnt, and give cdb_valid=0 in the next cycle; rr_ptr SHALL be preserved.
REQ-020 With more starving requesters than CDB_W, the lowest indices SHALL win; the others keep saturated counts.
REQ-021 cdb_busy SHALL be combinational: popcount(req_valid) > CDB_W, and forced 0 during flush.

Reset
REQ-022 On reset=1 at a clk edge: cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_rob=0, rr_ptr=0, every wait_cnt=0.
REQ-023 While reset=1, req_ready SHALL be 0 and cdb_busy SHALL be 0; reset SHALL take priority over flush.
REQ-024 Reset asserted mid-stream SHALL discard all pending grants; no transfer is reported for that cycle.

Structure
REQ-025 core_pkg SHALL hold preg_tag_t, ISSUE_WIDTH, PREGS and a new N_FU constant; STARVE_LIM stays local to this module.
REQ-026 The circular priority pick SHALL be one sub-module, rr_pick_n, which returns up to CDB_W one-hot grants from a request vector and a start pointer.

Verification
REQ-027 Single: req_valid=0001, tag 10, value 8, rob 0 -> req_ready=0001; next cycle cdb_valid=01, cdb_tag[0]=10, cdb_value[0]=8.
REQ-028 Full contention: req_valid=1111 held, rr_ptr=0 -> grants {0,1}, then {2,3}, then {0,1}; exactly two cdb_valid every cycle; cdb_busy=1.
REQ-029 Starvation: req 3 valid continuously while reqs 0,1 are re-asserted each cycle with rr_ptr forced to favour 0/1 -> req 3 is granted no later than its 5th waiting cycle, on port 0.
REQ-030 Flush: req_valid=0011 with flush=1 -> req_ready=00; next cycle cdb_valid=00; rr_ptr unchanged; wait_cnt=0.
REQ-031 Reset mid-stream: reset=1 during cycle with req_valid=1111 -> cdb_valid=00 next cycle, rr_ptr=0, req_ready=0000 during reset.
REQ-032 Issue-queue integration: cdb_* drive the issue_queue CDB inputs; I0 result p10=8 on ALU0 -> dependent MUL wakes and issues two cycles later.
